// File: rtl/bcd_convert_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_convert_arbiter
// Brief    : One iterative shift-add-3 (double-dabble) binary-to-BCD engine
//            shared between NUM_REQ requesters. Arbitration is round-robin
//            by default. Define BCD_ARB_FIXED_PRIORITY_EN to select fixed
//            priority, where the lowest set index always wins.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_convert_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int BIN_W      = 12,
    parameter  int BCD_DIGITS = 4,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*BIN_W-1:0]  bin_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      done,
    output logic [IDW-1:0]            done_id,
    output logic [4*BCD_DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state,   w_state_nxt;
    logic [NUM_REQ-1:0] r_grant,   w_grant_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_done,    w_done_nxt;
    logic [IDW-1:0]     r_done_id, w_done_id_nxt;
    logic [BCD_W-1:0]   r_bcd_out, w_bcd_out_nxt;
    logic [BCD_W-1:0]   r_bcd,     w_bcd_nxt;
    logic [BIN_W-1:0]   r_bin,     w_bin_nxt;
    logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
    logic [IDW-1:0]     r_id,      w_id_nxt;

    // Arbiter result
    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [NUM_REQ-1:0] w_onehot;

    // Datapath helpers
    logic [BCD_W-1:0]       w_corr;
    logic [BCD_W+BIN_W-1:0] w_sh;

`ifdef BCD_ARB_FIXED_PRIORITY_EN
    // Fixed priority: the first set request scanning up from index 0 wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i]) begin
                w_found = 1'b1;
                w_win   = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] r_ptr, w_ptr_nxt;
    int             w_idx;

    // Round-robin: search from the last winner + 1 upward, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(w_idx);
            end
        end
    end
`endif

    assign w_onehot = NUM_REQ'(1) << w_win;

    // Add-3 correction applied to every digit in parallel before each shift
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        assign w_corr[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? (r_bcd[4*g +: 4] + 4'd3)
                                                             : r_bcd[4*g +: 4];
    end

    // Combined shift of {bcd, bin}; the MSB falls off (cannot be set given
    // the digit-count constraint on BCD_DIGITS vs BIN_W)
    assign w_sh = {w_corr, r_bin} << 1;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = r_done_id;
        w_bcd_out_nxt = r_bcd_out;
        w_bcd_nxt     = r_bcd;
        w_bin_nxt     = r_bin;
        w_cnt_nxt     = r_cnt;
        w_id_nxt      = r_id;
`ifndef BCD_ARB_FIXED_PRIORITY_EN
        w_ptr_nxt     = r_ptr;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_onehot;
                    w_bcd_nxt   = '0;
                    w_bin_nxt   = bin_in[int'(w_win)*BIN_W +: BIN_W];
                    w_cnt_nxt   = CNT_W'(BIN_W);
                    w_busy_nxt  = 1'b1;
                    w_id_nxt    = w_win;
`ifndef BCD_ARB_FIXED_PRIORITY_EN
                    w_ptr_nxt   = w_win;
`endif
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_bcd_nxt = w_sh[BCD_W+BIN_W-1:BIN_W];
                w_bin_nxt = w_sh[BIN_W-1:0];
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_bcd_out_nxt = w_sh[BCD_W+BIN_W-1:BIN_W];
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_id;
                    w_grant_nxt   = '0;
                    w_state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion silently
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_bcd_out <= '0;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_id      <= '0;
`ifndef BCD_ARB_FIXED_PRIORITY_EN
            r_ptr     <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
            r_bcd_out <= w_bcd_out_nxt;
            r_bcd     <= w_bcd_nxt;
            r_bin     <= w_bin_nxt;
            r_cnt     <= w_cnt_nxt;
            r_id      <= w_id_nxt;
`ifndef BCD_ARB_FIXED_PRIORITY_EN
            r_ptr     <= w_ptr_nxt;
`endif
        end
    end

    assign grant   = r_grant;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign bcd_out = r_bcd_out;

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bcd_convert_arbiter
// Brief    : Directed self-checking bench for bcd_convert_arbiter
//            (4 requesters, 12-bit operands, 4 BCD digits). The fixed-priority
//            scenario is selected by BCD_ARB_FIXED_PRIORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_convert_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int BIN_W      = 12;
    localparam int BCD_DIGITS = 4;
    localparam int IDW        = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*BIN_W-1:0] bin_in;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic                     done;
    logic [IDW-1:0]           done_id;
    logic [4*BCD_DIGITS-1:0]  bcd_out;

    int checks = 0;
    int errors = 0;

    bcd_convert_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .BIN_W      (BIN_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .bin_in  (bin_in),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .bcd_out (bcd_out)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Advance one cycle and sample #1 after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Bounded wait for the next done pulse; cyc = edges elapsed
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (done !== 1'b1 && cyc < 40);
        check("done_timeout", 32'(done), 32'd1);
    endtask

    // Directed sequence
    initial begin
        int          cyc;
        int          seen;
        logic [15:0] exp3 [4];
        exp3 = '{16'h0000, 16'h0247, 16'h0658, 16'h4095};

        rst    = 1'b1;
        req    = '0;
        bin_in = '0;

        // 1. Reset with all requests asserted
        req = 4'b1111;
        tick();
        tick();
        check("rst_grant",   32'(grant),   32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_done",    32'(done),    32'h0);
        check("rst_bcd_out", 32'(bcd_out), 32'h0000);
        rst = 1'b0;
        tick();
        check("first_grant", 32'(grant), 32'b0001);

        // 2. Single request, 1204
        do_reset();
        bin_in[0 +: BIN_W] = 12'b010010110100;
        req = 4'b0001;
        tick();
        check("t2_grant", 32'(grant), 32'b0001);
        check("t2_busy",  32'(busy),  32'h1);
        seen = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        check("t2_early_done", 32'(seen), 32'd0);
        tick();
        check("t2_done",    32'(done),    32'h1);
        check("t2_bcd",     32'(bcd_out), 32'h1204);
        check("t2_done_id", 32'(done_id), 32'd0);
        check("t2_grant_0", 32'(grant),   32'h0);
        check("t2_busy_hi", 32'(busy),    32'h1);
        req = '0;
        tick();
        check("t2_done_lo", 32'(done),    32'h0);
        check("t2_busy_lo", 32'(busy),    32'h0);
        check("t2_hold",    32'(bcd_out), 32'h1204);

        // 3. All four requesting at once
        do_reset();
        bin_in[0*BIN_W +: BIN_W] = 12'd0;
        bin_in[1*BIN_W +: BIN_W] = 12'd247;
        bin_in[2*BIN_W +: BIN_W] = 12'd658;
        bin_in[3*BIN_W +: BIN_W] = 12'd4095;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(cyc);
            check("t3_spacing", 32'(cyc),     (k == 0) ? 32'd13 : 32'd14);
            check("t3_done_id", 32'(done_id), 32'(k));
            check("t3_bcd",     32'(bcd_out), 32'(exp3[k]));
            req[k] = 1'b0;
        end

`ifdef BCD_ARB_FIXED_PRIORITY_EN
        // 6. Fixed priority: index 0 starves index 3
        do_reset();
        bin_in[0*BIN_W +: BIN_W] = 12'd99;
        bin_in[3*BIN_W +: BIN_W] = 12'd1000;
        req = 4'b1001;
        tick();
        check("t6_grant", 32'(grant), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            wait_done(cyc);
            check("t6_done_id", 32'(done_id), 32'd0);
            check("t6_bcd",     32'(bcd_out), 32'h0099);
        end
        req = '0;
`else
        // 4. Fairness: req0 and req2 held continuously
        do_reset();
        bin_in[0*BIN_W +: BIN_W] = 12'd99;
        bin_in[2*BIN_W +: BIN_W] = 12'd1000;
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_done(cyc);
            check("t4_spacing", 32'(cyc),     (k == 0) ? 32'd13 : 32'd14);
            check("t4_done_id", 32'(done_id), (k % 2 == 0) ? 32'd0 : 32'd2);
            check("t4_bcd",     32'(bcd_out), (k % 2 == 0) ? 32'h0099 : 32'h1000);
        end
        req = '0;
`endif

        // 5. Reset in the middle of a conversion
        do_reset();
        tick();
        tick();
        bin_in[1*BIN_W +: BIN_W] = 12'd658;
        bin_in[3*BIN_W +: BIN_W] = 12'd33;
        req = 4'b0010;
        tick();
        check("t5_grant", 32'(grant), 32'b0010);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        rst = 1'b1;
        tick();
        if (done === 1'b1) seen++;
        check("t5_rst_grant",   32'(grant),   32'h0);
        check("t5_rst_busy",    32'(busy),    32'h0);
        check("t5_rst_done",    32'(done),    32'h0);
        check("t5_rst_done_id", 32'(done_id), 32'h0);
        check("t5_rst_bcd",     32'(bcd_out), 32'h0);
        rst = 1'b0;
        req = 4'b1010;
        tick();
        if (done === 1'b1) seen++;
        check("t5_no_done",     32'(seen),  32'd0);
        check("t5_regrant",     32'(grant), 32'b0010);
        wait_done(cyc);
        check("t5_latency",     32'(cyc),     32'd12);
        check("t5_done_id",     32'(done_id), 32'd1);
        check("t5_bcd",         32'(bcd_out), 32'h0658);
        req = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_convert_arbiter.md
Name: bcd_convert_arbiter

Overview:
- Shares one iterative shift-add-3 (double-dabble) binary-to-BCD engine between NUM_REQ requesters.
- Arbitrates the requests, latches the winner's operand and runs BIN_W shift cycles.
- Returns the packed BCD result with a one-cycle done pulse tagged with the requester index.
- Sits between the counter/FSM producers and the BCD display path, replacing one free-running converter per producer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BIN_W, 12, binary operand width.
- BCD_DIGITS, 4, output digits; must satisfy 10^BCD_DIGITS > 2^BIN_W - 1.
- IDW (localparam), $clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester.
- bin_in  in  NUM_REQ*BIN_W  packed operands; requester i uses bits [i*BIN_W +: BIN_W].
- grant  out  NUM_REQ  one-hot, high for the whole conversion of the granted requester.
- busy  out  1  engine occupied (SHIFT or DONE state).
- done  out  1  one-cycle pulse; bcd_out and done_id are valid while it is high.
- done_id  out  IDW  index of the requester whose result is on bcd_out.
- bcd_out  out  4*BCD_DIGITS  packed BCD result, most significant digit in the MSBs; holds until the next done.

Behaviour:
- Reset: all outputs 0. State = IDLE. Shift register and count = 0. Round-robin pointer = NUM_REQ-1, so index 0 has highest priority first.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, any req high at edge E0:
  - select the winner and set grant one-hot;
  - latch the winner's operand into the shift register and clear the BCD field;
  - set count = BIN_W, busy = 1, go to SHIFT;
  - update the pointer to the winner.
- IDLE with no req: outputs hold.
- SHIFT, edges E1..E_BIN_W, one step per edge:
  - every BCD digit >= 5 gets +3 (combinational, all digits in parallel);
  - then the whole {bcd, bin} register shifts left by 1;
  - count decrements.
- Last shift (count reaching 0), edge E_BIN_W:
  - bcd_out = corrected-and-shifted BCD field;
  - done = 1, done_id = winner index, grant = 0;
  - go to DONE.
- DONE, next edge: done = 0, busy = 0, go to IDLE.
- Latency: grant edge to done edge = BIN_W cycles (12). The earliest next grant is 2 edges after done, so back-to-back service has a period of BIN_W + 2 (14) cycles.
- Round-robin: search from pointer+1 upward, wrapping modulo NUM_REQ. The first set req wins.
- Requester protocol:
  - hold req and bin_in stable until grant; the operand is sampled only on the grant edge;
  - drop req on the cycle done is seen with its own done_id, otherwise it is re-queued.
- req deasserting mid-conversion: no abort; the conversion completes and done still pulses.
- bin_in changing after grant: no effect on the result.
- Simultaneous events: req edges during SHIFT/DONE are ignored until IDLE.
- rst asserted in any state, including mid-SHIFT:
  - reset values apply on that edge;
  - no done pulse is produced for the aborted conversion;
  - bcd_out = 0.
- Arithmetic: digit correction is 4-bit; a digit >= 5 plus 3 never exceeds 4'hC before the shift. BCD field width is 4*BCD_DIGITS; no overflow path exists given the parameter constraint.

Optional Feature:
- Macro: BCD_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority; the lowest-index set req always wins. The pointer register is removed. Starvation of higher indices is permitted.
- Undefined (default): round-robin as above.
- All other timing is identical in both modes.

Test Plan:
1. Reset: rst=1 for 2 cycles, with req=4'b1111 → grant=0, busy=0, done=0, bcd_out=16'h0000. After release, the first grant is grant=4'b0001.
2. Single request: req0=1, operand 12'b010010110100 (1204) → grant=0001 at E0; done pulses exactly 12 edges later with bcd_out=16'h1204, done_id=0; busy falls one edge after done.
3. All four requesting at once, operands 0, 247, 658, 4095; each req dropped after its done → grants in order 0,1,2,3; results 16'h0000, 16'h0247, 16'h0658, 16'h4095; grants spaced 14 cycles apart.
4. Fairness: req0 and req2 held high continuously, operands 99 and 1000 → grants alternate 0,2,0,2; bcd_out alternates 16'h0099 / 16'h1000.
5. Reset mid-conversion: req1 with 658, rst pulsed at the 6th SHIFT edge → all outputs 0 on the next edge, no done. After release with req1 and req3 pending, the first grant goes to index 1.
6. With BCD_ARB_FIXED_PRIORITY_EN defined: req0 and req3 held continuously → grant is always 0001; no done with done_id=3 within 5 conversions.
